// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word width, RAM status codes and arbiter states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between fetch, data stage, the shared RAM port and the arbiter.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;

    logic      ihit;
    logic      dhit;
    word_t     imemload;
    word_t     dmemload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      err;

    // master: the arbiter, which owns the RAM strobes and the completion pulses
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Counts data grants completed while fetch waits; sat tells the arbiter to favour fetch.
module starve_counter #(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access with starvation-bounded data priority.
// Define MEM_ARBITER_STATS_EN to add igrant_cnt/dgrant_cnt completion counters.
//
//   state | meaning
//   IDLE  | no grant, RAM strobes low, choosing next grantee
//   IGNT  | instruction fetch owns the RAM port
//   DGNT  | data access owns the RAM port
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]   igrant_cnt,
    output logic [31:0]   dgrant_cnt
`endif
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              d_req;
    logic              starve_sat;
    logic              starve_inc;
    logic              starve_clr;
    logic [ADDR_W-1:0] addr_sel;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .CLK (CLK),
        .RST (RST),
        .inc (starve_inc),
        .clr (starve_clr),
        .sat (starve_sat)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
`ifdef MEM_ARBITER_STATS_EN
            igrant_cnt <= '0;
            dgrant_cnt <= '0;
`endif
        end else begin
            state_q    <= state_d;
`ifdef MEM_ARBITER_STATS_EN
            if (bus.ihit) igrant_cnt <= igrant_cnt + 32'd1;
            if (bus.dhit) dgrant_cnt <= dgrant_cnt + 32'd1;
`endif
        end
    end

    // A dropped request aborts the grant before ACCESS/ERROR is considered.
    always_comb begin
        state_d      = state_q;
        d_req        = bus.dREN | bus.dWEN;
        addr_sel     = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.err      = 1'b0;
        bus.imemload = '0;
        bus.dmemload = '0;

        case (state_q)
            IDLE: begin
                if (d_req && !starve_sat) begin
                    state_d = DGNT;
                end else if (bus.iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                bus.ramREN = 1'b1;
                addr_sel   = bus.iaddr;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.ihit     = 1'b1;
                    bus.imemload = bus.ramload;
                    state_d      = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    bus.err = 1'b1;
                    state_d = IDLE;
                end
            end
            DGNT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                addr_sel     = bus.daddr;
                bus.ramstore = bus.dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.dhit     = 1'b1;
                    bus.dmemload = bus.ramload;
                    state_d      = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    bus.err = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bus.ramaddr = addr_sel;
        starve_inc  = bus.dhit & bus.iREN;
        starve_clr  = bus.ihit | ((state_q == IDLE) & ~bus.iREN);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (who owns the port, how many data grants fetch has waited through).
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_MAX = 4;

    logic CLK = 1'b0;
    logic RST;

    mem_arbiter_if bus ();

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] igrant_cnt;
    logic [31:0] dgrant_cnt;
`endif

    mem_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .ADDR_W     (32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .igrant_cnt (igrant_cnt),
        .dgrant_cnt (dgrant_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: owner 0 = nobody, 1 = fetch, 2 = data; waits = data grants fetch has sat through.
    int owner = 0;
    int waits = 0;
    int n_ihit = 0;
    int n_dhit = 0;
    logic [15:0] hit_trace;
    int hit_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input logic iren, input logic dren, input logic dwen, input ramstate_t rs);
        bus.iREN     = iren;
        bus.dREN     = dren;
        bus.dWEN     = dwen;
        bus.ramstate = rs;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ihit"}, bus.ihit, 1'b0);
        check({tag, "_dhit"}, bus.dhit, 1'b0);
        check({tag, "_err"}, bus.err, 1'b0);
        check({tag, "_ren"}, bus.ramREN, 1'b0);
        check({tag, "_wen"}, bus.ramWEN, 1'b0);
        check({tag, "_addr"}, bus.ramaddr, 32'h0);
        check({tag, "_store"}, bus.ramstore, 32'h0);
        check({tag, "_iload"}, bus.imemload, 32'h0);
        check({tag, "_dload"}, bus.dmemload, 32'h0);
`ifdef MEM_ARBITER_STATS_EN
        check({tag, "_icnt"}, igrant_cnt, 32'h0);
        check({tag, "_dcnt"}, dgrant_cnt, 32'h0);
`endif
    endtask

    task automatic model_reset();
        owner  = 0;
        waits  = 0;
        n_ihit = 0;
        n_dhit = 0;
    endtask

    // Called at posedge+1; returns at the following posedge+1 with reset released.
    task automatic apply_reset();
        RST = 1'b1;
        #1;
        check_zero("rst");
        model_reset();
        tick();
        RST = 1'b0;
    endtask

    // Samples outputs mid-cycle, compares with the model, then advances the model to the next edge.
    task automatic eval_cycle();
        logic dreq, oreq, done, e_ihit, e_dhit;
        int   nxt;
        #3;
        dreq   = bus.dREN | bus.dWEN;
        oreq   = (owner == 1) ? bus.iREN : ((owner == 2) ? dreq : 1'b0);
        done   = oreq && (bus.ramstate == ACCESS);
        e_ihit = (owner == 1) && done;
        e_dhit = (owner == 2) && done;

        check("ihit", bus.ihit, e_ihit);
        check("dhit", bus.dhit, e_dhit);
        check("err", bus.err, oreq && (bus.ramstate == ERROR));
        check("imemload", bus.imemload, e_ihit ? bus.ramload : 32'h0);
        check("dmemload", bus.dmemload, e_dhit ? bus.ramload : 32'h0);
        check("ramREN", bus.ramREN, (owner == 1) || ((owner == 2) && bus.dREN && !bus.dWEN));
        check("ramWEN", bus.ramWEN, (owner == 2) && bus.dWEN);
        check("ramaddr", bus.ramaddr, (owner == 1) ? bus.iaddr : ((owner == 2) ? bus.daddr : 32'h0));
        check("ramstore", bus.ramstore, (owner == 2) ? bus.dstore : 32'h0);
        check("both_hits", bus.ihit & bus.dhit, 1'b0);
`ifdef MEM_ARBITER_STATS_EN
        check("igrant_cnt", igrant_cnt, 32'(n_ihit));
        check("dgrant_cnt", dgrant_cnt, 32'(n_dhit));
`endif
        if (bus.ihit || bus.dhit) begin
            hit_trace = {hit_trace[14:0], bus.ihit};
            hit_n++;
        end

        if (owner == 0) nxt = (dreq && waits < STARVE_MAX) ? 2 : (bus.iREN ? 1 : 0);
        else            nxt = (!oreq || bus.ramstate == ACCESS || bus.ramstate == ERROR) ? 0 : owner;

        if (e_ihit || (owner == 0 && !bus.iREN)) waits = 0;
        else if (e_dhit && bus.iREN && waits < STARVE_MAX) waits++;

        if (e_ihit) n_ihit++;
        if (e_dhit) n_dhit++;
        owner = nxt;
    endtask

    task automatic drive_rand();
        int r;
        bus.iREN    = ($urandom_range(0, 9) < 7);
        bus.dREN    = ($urandom_range(0, 9) < 5);
        bus.dWEN    = ($urandom_range(0, 9) < 3);
        bus.iaddr   = $urandom;
        bus.daddr   = $urandom;
        bus.dstore  = $urandom;
        bus.ramload = $urandom;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    bus.ramstate = FREE;
            2, 3:    bus.ramstate = BUSY;
            9:       bus.ramstate = ERROR;
            default: bus.ramstate = ACCESS;
        endcase
    endtask

    initial begin
        int wcnt;
        RST = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, FREE);
        bus.iaddr   = '0;
        bus.daddr   = '0;
        bus.dstore  = '0;
        bus.ramload = '0;
        hit_trace   = '0;
        hit_n       = 0;
        #1;
        check_zero("por");
        tick();
        RST = 1'b0;

        // Single fetch: grant one cycle after request, hit when ACCESS arrives.
        set_req(1'b1, 1'b0, 1'b0, FREE);
        bus.iaddr   = 32'h100;
        bus.ramload = 32'hCAFE_0001;
        eval_cycle(); tick();
        eval_cycle();
        check("fetch_ren", bus.ramREN, 1'b1);
        check("fetch_addr", bus.ramaddr, 32'h100);
        tick();
        bus.ramstate = ACCESS;
        eval_cycle();
        check("fetch_hit", bus.ihit, 1'b1);
        check("fetch_load", bus.imemload, 32'hCAFE_0001);
        tick();

        // Competing fetch and data: STARVE_MAX data grants then one fetch, repeating.
        apply_reset();
        set_req(1'b1, 1'b1, 1'b0, ACCESS);
        bus.daddr = 32'h200;
        hit_trace = '0;
        hit_n     = 0;
        repeat (20) begin
            eval_cycle(); tick();
        end
        check("starve_pattern", hit_trace[9:0], 10'h021);
        check("starve_hits", hit_n, 10);

        // Write with three wait states.
        apply_reset();
        set_req(1'b0, 1'b1, 1'b1, BUSY);
        bus.daddr  = 32'h300;
        bus.dstore = 32'hDEAD_BEEF;
        wcnt = 0;
        eval_cycle(); tick();
        for (int k = 1; k <= 4; k++) begin
            bus.ramstate = (k < 4) ? BUSY : ACCESS;
            eval_cycle();
            if (bus.ramWEN && !bus.ramREN) wcnt++;
            if (k == 4) check("write_dhit", bus.dhit, 1'b1);
            else        check("write_wait", bus.dhit, 1'b0);
            tick();
        end
        check("write_cycles", wcnt, 4);
        set_req(1'b0, 1'b0, 1'b0, FREE);

        // Fetch aborted by a flush while the RAM is busy.
        apply_reset();
        set_req(1'b1, 1'b0, 1'b0, BUSY);
        eval_cycle(); tick();
        eval_cycle(); tick();
        bus.iREN = 1'b0;
        eval_cycle();
        check("abort_nohit", bus.ihit, 1'b0);
        tick();
        eval_cycle();
        check("abort_idle_ren", bus.ramREN, 1'b0);
        tick();

        // RAM error during a data grant.
        apply_reset();
        set_req(1'b0, 1'b1, 1'b0, ERROR);
        eval_cycle(); tick();
        eval_cycle();
        check("error_err", bus.err, 1'b1);
        check("error_nohit", bus.dhit, 1'b0);
        tick();
        bus.dREN = 1'b0;
        eval_cycle();
        check("error_idle_ren", bus.ramREN, 1'b0);
        tick();

        // Reset asserted in the middle of a fetch grant.
        apply_reset();
        set_req(1'b1, 1'b0, 1'b0, BUSY);
        bus.iaddr = 32'h440;
        eval_cycle(); tick();
        eval_cycle(); tick();
        #1;
        check("midrst_pre_ren", bus.ramREN, 1'b1);
        RST = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        tick();
        RST = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, FREE);

`ifdef MEM_ARBITER_STATS_EN
        apply_reset();
        set_req(1'b1, 1'b0, 1'b0, ACCESS);
        repeat (6) begin
            eval_cycle(); tick();
        end
        set_req(1'b0, 1'b1, 1'b0, ACCESS);
        repeat (4) begin
            eval_cycle(); tick();
        end
        set_req(1'b0, 1'b0, 1'b0, FREE);
        #3;
        check("stats_icnt", igrant_cnt, 32'd3);
        check("stats_dcnt", dgrant_cnt, 32'd2);
        #(-3 + 3);
        tick();
        apply_reset();
`endif

        // Randomized traffic with occasional resets.
        apply_reset();
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            drive_rand();
            eval_cycle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
